// File: rtl/skolem_bvugt_bvor_checker_if.sv
// Bus between the Skolem checker and its driver / Skolem stage.
// master: sweep control, witness source and status sink; slave: the checker.
interface skolem_bvugt_bvor_checker_if #(
    parameter int W = 2
);
    logic           start;
    logic           abort;
    logic [W-1:0]   s_out;
    logic [W-1:0]   t_out;
    logic [W-1:0]   x_in;
    logic           busy;
    logic           done;
    logic           pass;
    logic [2*W:0]   fail_count;
    logic           first_fail_valid;
    logic [W-1:0]   first_fail_s;
    logic [W-1:0]   first_fail_t;

    modport master (
        output start,
        output abort,
        output x_in,
        input  s_out,
        input  t_out,
        input  busy,
        input  done,
        input  pass,
        input  fail_count,
        input  first_fail_valid,
        input  first_fail_s,
        input  first_fail_t
    );

    modport slave (
        input  start,
        input  abort,
        input  x_in,
        output s_out,
        output t_out,
        output busy,
        output done,
        output pass,
        output fail_count,
        output first_fail_valid,
        output first_fail_s,
        output first_fail_t
    );
endinterface

// File: rtl/skolem_bvugt_bvor_checker.sv
// Exhaustive checker of a Skolem witness for (x | s) >u t over all (s,t).
// Ports: clk, rst_n (async low), bus (slave): start/abort in, s/t out, x in, status out.
module skolem_bvugt_bvor_checker #(
    parameter int W   = 2,
    parameter int LAT = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    skolem_bvugt_bvor_checker_if.slave    bus
);

    localparam int NW = 2 * W;
    localparam int FW = 2 * W + 1;
    localparam logic [3:0] LAT_V = 4'(LAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [NW-1:0]   idx_q, idx_d;
    logic [3:0]      wait_q, wait_d;
    logic [FW-1:0]   fail_q, fail_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic            ffv_q, ffv_d;
    logic [W-1:0]    ffs_q, ffs_d;
    logic [W-1:0]    fft_q, fft_d;

    logic [W-1:0]    s_cur;
    logic [W-1:0]    t_cur;
    logic            ic;
    logic            ok;
    logic            last;
    logic [FW-1:0]   fail_inc;

    assign s_cur = idx_q[NW-1:W];
    assign t_cur = idx_q[W-1:0];

    // t = all-ones has no solution, so any witness is acceptable there.
    always_comb begin
        ic       = (t_cur != {W{1'b1}});
        ok       = !ic || ((bus.x_in | s_cur) > t_cur);
        last     = (idx_q == {NW{1'b1}});
        fail_inc = fail_q + FW'(1);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        fail_d  = fail_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        ffv_d   = ffv_q;
        ffs_d   = ffs_q;
        fft_d   = fft_q;

        unique case (state_q)
            IDLE: begin
                // abort beats a simultaneous start
                if (bus.start && !bus.abort) begin
                    state_d = APPLY;
                    idx_d   = '0;
                    wait_d  = LAT_V;
                    fail_d  = '0;
                    pass_d  = 1'b0;
                    ffv_d   = 1'b0;
                    ffs_d   = '0;
                    fft_d   = '0;
                    busy_d  = 1'b1;
                end
            end

            APPLY: begin
                if (bus.abort) begin
                    // vector under evaluation is dropped, stats kept
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    pass_d  = 1'b0;
                end else if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else begin
                    if (!ok) begin
                        fail_d = fail_inc;
                        if (!ffv_q) begin
                            ffv_d = 1'b1;
                            ffs_d = s_cur;
                            fft_d = t_cur;
                        end
                    end
                    if (last) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = ok ? (fail_q == '0) : 1'b0;
                    end else begin
                        idx_d  = idx_q + NW'(1);
                        wait_d = LAT_V;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            wait_q  <= '0;
            fail_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            ffv_q   <= 1'b0;
            ffs_q   <= '0;
            fft_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            fail_q  <= fail_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            ffv_q   <= ffv_d;
            ffs_q   <= ffs_d;
            fft_q   <= fft_d;
        end
    end

    assign bus.s_out            = s_cur;
    assign bus.t_out            = t_cur;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = pass_q;
    assign bus.fail_count       = fail_q;
    assign bus.first_fail_valid = ffv_q;
    assign bus.first_fail_s     = ffs_q;
    assign bus.first_fail_t     = fft_q;

endmodule

// File: tb/tb_skolem_bvugt_bvor_checker.sv
// Directed bench for the Skolem checker: LAT=0 with a tied witness,
// LAT=2 with a two-stage pipelined witness model.
module tb_skolem_bvugt_bvor_checker;

    logic       clk;
    logic       rst_n;
    logic       sel;
    logic       start_v;
    logic       abort_v;
    logic [1:0] x0;
    logic       wrong;
    logic [1:0] p1;
    logic [1:0] p2;
    int         total;
    int         bad;
    int         bcnt;

    skolem_bvugt_bvor_checker_if #(.W(2)) i0 ();
    skolem_bvugt_bvor_checker_if #(.W(2)) i2 ();

    skolem_bvugt_bvor_checker #(.W(2), .LAT(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (i0.slave)
    );

    skolem_bvugt_bvor_checker #(.W(2), .LAT(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (i2.slave)
    );

    assign i0.start = start_v & ~sel;
    assign i2.start = start_v & sel;
    assign i0.abort = abort_v & ~sel;
    assign i2.abort = abort_v & sel;
    assign i0.x_in  = x0;
    assign i2.x_in  = p2;

    always @(posedge clk) begin
        p1 <= (wrong && i2.s_out == 2'd1 && i2.t_out == 2'd2) ? 2'b00 : 2'b11;
        p2 <= p1;
    end

    wire       done_m = sel ? i2.done : i0.done;
    wire       busy_m = sel ? i2.busy : i0.busy;
    wire       pass_m = sel ? i2.pass : i0.pass;
    wire [4:0] fc_m   = sel ? i2.fail_count : i0.fail_count;
    wire       ffv_m  = sel ? i2.first_fail_valid : i0.first_fail_valid;
    wire [1:0] ffs_m  = sel ? i2.first_fail_s : i0.first_fail_s;
    wire [1:0] fft_m  = sel ? i2.first_fail_t : i0.first_fail_t;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int pulse_at, output int bc);
        start_v = 1'b1;
        tick();
        start_v = 1'b0;
        bc = 0;
        for (int k = 0; k < 200 && !done_m; k++) begin
            if (busy_m) bc++;
            start_v = (k == pulse_at);
            tick();
        end
        start_v = 1'b0;
        check("done_seen", done_m, 1);
    endtask

    task automatic wait_idx(input logic [3:0] v);
        int k;
        k = 0;
        while ({i0.s_out, i0.t_out} != v && k < 100) begin
            tick();
            k++;
        end
        check("idx_reached", {i0.s_out, i0.t_out}, v);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        sel     = 1'b0;
        start_v = 1'b0;
        abort_v = 1'b0;
        x0      = 2'b11;
        wrong   = 1'b0;
        tick();
        tick();
        check("rst_busy", i0.busy, 0);
        check("rst_done", i0.done, 0);
        check("rst_pass", i0.pass, 0);
        check("rst_fc", i0.fail_count, 0);
        check("rst_ffv", i0.first_fail_valid, 0);
        check("rst_st", {i0.s_out, i0.t_out}, 0);
        rst_n = 1'b1;
        tick();

        // all-ones witness always satisfies
        run(-1, bcnt);
        check("ones_busy", bcnt, 16);
        check("ones_pass", pass_m, 1);
        check("ones_fc", fc_m, 0);
        check("ones_ffv", ffv_m, 0);
        tick();
        check("done_1cyc", done_m, 0);
        check("pass_hold", pass_m, 1);

        // zero witness fails s<=t, t!=3
        x0 = 2'b00;
        run(-1, bcnt);
        check("zero_pass", pass_m, 0);
        check("zero_fc", fc_m, 6);
        check("zero_ffv", ffv_m, 1);
        check("zero_ffs", ffs_m, 0);
        check("zero_fft", fft_m, 0);
        tick();

        // start while busy is ignored
        x0 = 2'b11;
        run(4, bcnt);
        check("restart_busy", bcnt, 16);
        check("restart_pass", pass_m, 1);
        tick();

        // abort at idx 7, only 0..6 counted
        x0 = 2'b00;
        start_v = 1'b1;
        tick();
        start_v = 1'b0;
        wait_idx(4'd7);
        abort_v = 1'b1;
        tick();
        abort_v = 1'b0;
        check("abort_busy", i0.busy, 0);
        check("abort_done", i0.done, 0);
        check("abort_fc", i0.fail_count, 5);
        check("abort_pass", i0.pass, 0);
        tick();
        check("abort_nodone", i0.done, 0);

        // abort beats start in idle
        start_v = 1'b1;
        abort_v = 1'b1;
        tick();
        start_v = 1'b0;
        abort_v = 1'b0;
        check("sa_busy", i0.busy, 0);
        tick();
        check("sa_busy2", i0.busy, 0);

        // LAT=2 pipelined witness
        sel   = 1'b1;
        wrong = 1'b0;
        tick();
        run(-1, bcnt);
        check("lat2_busy", bcnt, 48);
        check("lat2_pass", pass_m, 1);
        check("lat2_fc", fc_m, 0);
        tick();
        wrong = 1'b1;
        run(-1, bcnt);
        check("lat2w_busy", bcnt, 48);
        check("lat2w_pass", pass_m, 0);
        check("lat2w_fc", fc_m, 1);
        check("lat2w_ffs", ffs_m, 1);
        check("lat2w_fft", fft_m, 2);
        tick();

        // reset mid-sweep at idx 9
        sel = 1'b0;
        x0  = 2'b00;
        start_v = 1'b1;
        tick();
        start_v = 1'b0;
        wait_idx(4'd9);
        rst_n = 1'b0;
        #1;
        check("mrst_busy", i0.busy, 0);
        check("mrst_st", {i0.s_out, i0.t_out}, 0);
        check("mrst_fc", i0.fail_count, 0);
        check("mrst_ffv", i0.first_fail_valid, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("mrst_idle", i0.busy, 0);

        // sweep after reset, then start held across done
        start_v = 1'b1;
        tick();
        for (int k = 0; k < 100 && !i0.done; k++) tick();
        check("held_done", i0.done, 1);
        check("held_fc1", i0.fail_count, 6);
        x0 = 2'b11;
        tick();
        check("held_idle", i0.busy, 0);
        tick();
        check("held_busy", i0.busy, 1);
        check("held_fc0", i0.fail_count, 0);
        check("held_pass0", i0.pass, 0);
        start_v = 1'b0;
        for (int k = 0; k < 100 && !i0.done; k++) tick();
        check("held_done2", i0.done, 1);
        check("held_pass", i0.pass, 1);
        check("held_fc", i0.fail_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
